// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: bus widths, access sizes,
// FSM state encoding and the latched request record.
package dmem_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned BE_W   = DATA_W / 8;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              we;
    logic [1:0]        size;
    logic              uns;
  } req_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response handshake bundle between the MEM stage and the data memory.
interface dmem_responder_if;
  import dmem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_addr, req_wdata, req_we, req_size, req_unsigned, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_addr, req_wdata, req_we, req_size, req_unsigned, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/dmem_array.sv
// Single-port word storage with per-byte write enables and combinational read.
// Contents are intentionally not reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic              clk,
  input  logic [BE_W-1:0]   be,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int b = 0; b < int'(BE_W); b++) begin
      if (be[b]) mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  assign rdata = mem_q[idx];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory target: accepts one request, waits WAIT_STATES cycles,
// commits the access and holds a registered response until it is taken.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0100_0000,
  parameter int unsigned WAIT_STATES = 2
) (
  input logic             clk,
  input logic             reset,
  dmem_responder_if.slave bus
);

  localparam int unsigned       IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [ADDR_W-1:0] SPAN      = ADDR_W'(DEPTH_WORDS * 4);
  localparam logic [CNT_W-1:0]  WAIT_INIT = CNT_W'(WAIT_STATES);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  req_t              req_q, req_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;

  req_t              req_in_c, acc_c;
  logic [ADDR_W-1:0] offset_c;
  logic [1:0]        lane_c;
  logic [IDX_W-1:0]  idx_c;
  logic              err_c, commit_c;
  logic [BE_W-1:0]   be_c;
  logic [DATA_W-1:0] wdata_lane_c, rd_word_c, shifted_c, load_c;

  always_comb begin
    req_in_c.addr  = bus.req_addr;
    req_in_c.wdata = bus.req_wdata;
    req_in_c.we    = bus.req_we;
    req_in_c.size  = bus.req_size;
    req_in_c.uns   = bus.req_unsigned;
  end

  // With zero wait states the access commits on the acceptance edge itself,
  // so the live request fields feed the datapath while idle.
  always_comb begin
    acc_c    = (state_q == ST_IDLE) ? req_in_c : req_q;
    offset_c = acc_c.addr - BASE_ADDR;
    lane_c   = offset_c[1:0];
    idx_c    = offset_c[IDX_W+1:2];
    commit_c = ((state_q == ST_IDLE) && bus.req_valid && (WAIT_INIT == '0)) ||
               ((state_q == ST_WAIT) && (cnt_q <= CNT_W'(1)));
  end

  // Alignment, size and range checks.
  always_comb begin
    err_c = 1'b0;
    case (acc_c.size)
      SIZE_BYTE: err_c = 1'b0;
      SIZE_HALF: err_c = lane_c[0];
      SIZE_WORD: err_c = (lane_c != 2'b00);
      default:   err_c = 1'b1;
    endcase
    if (offset_c >= SPAN) err_c = 1'b1;
  end

  // Byte-lane write enables with store data replicated across lanes.
  always_comb begin
    be_c         = '0;
    wdata_lane_c = acc_c.wdata;
    case (acc_c.size)
      SIZE_BYTE: begin
        be_c         = BE_W'(4'b0001 << lane_c);
        wdata_lane_c = {4{acc_c.wdata[7:0]}};
      end
      SIZE_HALF: begin
        be_c         = BE_W'(4'b0011 << lane_c);
        wdata_lane_c = {2{acc_c.wdata[15:0]}};
      end
      SIZE_WORD: be_c = '1;
      default:   be_c = '0;
    endcase
    if (!(commit_c && acc_c.we && !err_c)) be_c = '0;
  end

  // Load lane extraction and sign/zero extension.
  always_comb begin
    shifted_c = rd_word_c >> {lane_c, 3'b000};
    case (acc_c.size)
      SIZE_BYTE: load_c = acc_c.uns ? {24'b0, shifted_c[7:0]}
                                    : {{24{shifted_c[7]}}, shifted_c[7:0]};
      SIZE_HALF: load_c = acc_c.uns ? {16'b0, shifted_c[15:0]}
                                    : {{16{shifted_c[15]}}, shifted_c[15:0]};
      default:   load_c = rd_word_c;
    endcase
  end

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk   (clk),
    .be    (be_c),
    .idx   (idx_c),
    .wdata (wdata_lane_c),
    .rdata (rd_word_c)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_d        = req_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          req_d   = req_in_c;
          cnt_d   = WAIT_INIT;
          state_d = (WAIT_INIT == '0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (bus.resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (commit_c) begin
      err_d   = err_c;
      rdata_d = (err_c || acc_c.we) ? '0 : load_c;
    end
    req_ready_d  = (state_d == ST_IDLE);
    resp_valid_d = (state_d == ST_RESP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      req_q        <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_q        <= req_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

endmodule
